// File: rtl/sram_transpose_buf.sv
// sram_transpose_buf: multi-tile row/column transpose buffer for complex samples.
//
// Each tile is a Lanes x Lanes matrix. Element (r,c) of tile t is stored in
// bank (r+c) mod Lanes at address t*Lanes+r. Because of this skew, any full
// row or any full column touches every bank exactly once, so it can be written
// or read in a single cycle.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   wr_valid_i / wr_ready_o       write vector handshake
//   wr_col_i, wr_tile_i, wr_idx_i write orientation (1=column), tile, row/col index
//   wr_re_i / wr_im_i             write vector, lane k at [k*DataWidth +: DataWidth]
//   rd_req_valid_i/rd_req_ready_o read request handshake
//   rd_col_i, rd_tile_i, rd_idx_i read orientation, tile, row/col index
//   rd_valid_o, rd_re_o, rd_im_o  read vector, valid two cycles after accept

// Single-port bank: one read or one write per cycle, registered read data.
module sram_transpose_bank #(
    parameter int Depth = 8,
    parameter int Width = 32,
    parameter int AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o
);
    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            else      rdata_q       <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

module sram_transpose_buf #(
    parameter int Lanes     = 4,
    parameter int NumTiles  = 2,
    parameter int DataWidth = 16,
    localparam int TW = (NumTiles > 1) ? $clog2(NumTiles) : 1,
    localparam int IW = $clog2(Lanes)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic                       wr_col_i,
    input  logic [TW-1:0]              wr_tile_i,
    input  logic [IW-1:0]              wr_idx_i,
    input  logic [Lanes*DataWidth-1:0] wr_re_i,
    input  logic [Lanes*DataWidth-1:0] wr_im_i,
    input  logic                       rd_req_valid_i,
    output logic                       rd_req_ready_o,
    input  logic                       rd_col_i,
    input  logic [TW-1:0]              rd_tile_i,
    input  logic [IW-1:0]              rd_idx_i,
    output logic                       rd_valid_o,
    output logic [Lanes*DataWidth-1:0] rd_re_o,
    output logic [Lanes*DataWidth-1:0] rd_im_o
);
    localparam int Depth = NumTiles * Lanes;
    localparam int AW    = $clog2(Depth);
    localparam int CW    = $clog2(Lanes + 1);
    localparam int BW    = 2 * DataWidth;
    // Counter slots cover every encodable tile id; slots >= NumTiles never move.
    localparam int Slots = 1 << TW;
    localparam logic [TW:0] NumTilesL = (TW+1)'(NumTiles);

    logic [CW-1:0] wcnt_q [Slots];
    logic [CW-1:0] wcnt_d [Slots];
    logic [IW-1:0] rcnt_q [Slots];
    logic [IW-1:0] rcnt_d [Slots];
    logic          prio_q, prio_d;

    logic wr_tile_ok, rd_tile_ok, wr_elig, rd_elig, wr_go, rd_go;

    // ---------------- arbitration ----------------
    assign wr_tile_ok = {1'b0, wr_tile_i} < NumTilesL;
    assign rd_tile_ok = {1'b0, rd_tile_i} < NumTilesL;
    assign wr_elig = wr_valid_i & wr_tile_ok & (wcnt_q[wr_tile_i] != CW'(Lanes));
    assign rd_elig = rd_req_valid_i & rd_tile_ok & (wcnt_q[rd_tile_i] == CW'(Lanes));

    // Every access occupies all banks, so at most one side is served per cycle.
    assign wr_go = wr_elig & (~rd_elig | ~prio_q);
    assign rd_go = rd_elig & (~wr_elig | prio_q);
    assign wr_ready_o     = wr_go;
    assign rd_req_ready_o = rd_go;

    // Priority moves to the loser, and only when both sides competed.
    assign prio_d = (wr_elig & rd_elig) ? ~prio_q : prio_q;

    // ---------------- tile fill/drain tracking ----------------
    always_comb begin
        for (int t = 0; t < Slots; t++) begin
            wcnt_d[t] = wcnt_q[t];
            rcnt_d[t] = rcnt_q[t];
        end
        if (wr_go) wcnt_d[wr_tile_i] = wcnt_q[wr_tile_i] + CW'(1);
        if (rd_go) begin
            if (rcnt_q[rd_tile_i] == IW'(Lanes - 1)) begin
                // Last drain read releases the tile for refilling.
                wcnt_d[rd_tile_i] = '0;
                rcnt_d[rd_tile_i] = '0;
            end else begin
                rcnt_d[rd_tile_i] = rcnt_q[rd_tile_i] + IW'(1);
            end
        end
    end

    // ---------------- banks ----------------
    logic [Lanes-1:0][BW-1:0] bank_rd;

    for (genvar b = 0; b < Lanes; b++) begin : g_bank
        logic [IW-1:0] wsub, rsub, wrow, rrow;
        logic [AW-1:0] waddr, raddr, addr;
        logic [BW-1:0] wdata;

        // (b - idx) mod Lanes is both the lane that feeds this bank and,
        // in column mode, the row this bank holds for that column.
        assign wsub  = IW'(b) - wr_idx_i;
        assign rsub  = IW'(b) - rd_idx_i;
        assign wrow  = wr_col_i ? wsub : wr_idx_i;
        assign rrow  = rd_col_i ? rsub : rd_idx_i;
        assign waddr = AW'(wr_tile_i) * AW'(Lanes) + AW'(wrow);
        assign raddr = AW'(rd_tile_i) * AW'(Lanes) + AW'(rrow);
        assign addr  = rd_go ? raddr : waddr;
        assign wdata = {wr_im_i[wsub*DataWidth +: DataWidth],
                        wr_re_i[wsub*DataWidth +: DataWidth]};

        sram_transpose_bank #(
            .Depth (Depth),
            .Width (BW),
            .AddrW (AW)
        ) u_bank (
            .clk_i   (clk_i),
            .en_i    (wr_go | rd_go),
            .we_i    (wr_go),
            .addr_i  (addr),
            .wdata_i (wdata),
            .rdata_o (bank_rd[b])
        );
    end

    // ---------------- read pipeline ----------------
    logic [2:1]                 vld_pipe_q;
    logic [IW-1:0]              ridx_q;
    logic [Lanes*DataWidth-1:0] rot_re, rot_im, rd_re_q, rd_im_q;
    logic [IW-1:0]              sel;

    // Output lane k comes from bank (k + idx) mod Lanes for rows and columns alike.
    always_comb begin
        rot_re = '0;
        rot_im = '0;
        sel    = '0;
        for (int k = 0; k < Lanes; k++) begin
            sel = IW'(k) + ridx_q;
            rot_re[k*DataWidth +: DataWidth] = bank_rd[sel][DataWidth-1:0];
            rot_im[k*DataWidth +: DataWidth] = bank_rd[sel][BW-1:DataWidth];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int t = 0; t < Slots; t++) begin
                wcnt_q[t] <= '0;
                rcnt_q[t] <= '0;
            end
            prio_q     <= 1'b0;
            vld_pipe_q <= '0;
            ridx_q     <= '0;
            rd_re_q    <= '0;
            rd_im_q    <= '0;
        end else begin
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            prio_q     <= prio_d;
            vld_pipe_q <= {vld_pipe_q[1], rd_go};
            if (rd_go) ridx_q <= rd_idx_i;
            // Output holds its last vector when no read is landing.
            if (vld_pipe_q[1]) begin
                rd_re_q <= rot_re;
                rd_im_q <= rot_im;
            end
        end
    end

    assign rd_valid_o = vld_pipe_q[2];
    assign rd_re_o    = rd_re_q;
    assign rd_im_o    = rd_im_q;
endmodule

// File: tb/tb_sram_transpose_buf.sv
module tb_sram_transpose_buf;
    localparam int L  = 4;
    localparam int NT = 2;
    localparam int DW = 16;
    localparam int TW = 1;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            wr_valid = 1'b0, wr_ready, wr_col = 1'b0;
    logic [TW-1:0]   wr_tile = '0;
    logic [IW-1:0]   wr_idx = '0;
    logic [L*DW-1:0] wr_re = '0, wr_im = '0;
    logic            rd_req_valid = 1'b0, rd_req_ready, rd_col = 1'b0;
    logic [TW-1:0]   rd_tile = '0;
    logic [IW-1:0]   rd_idx = '0;
    logic            rd_valid;
    logic [L*DW-1:0] rd_re, rd_im;

    sram_transpose_buf #(.Lanes(L), .NumTiles(NT), .DataWidth(DW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .wr_valid_i     (wr_valid),
        .wr_ready_o     (wr_ready),
        .wr_col_i       (wr_col),
        .wr_tile_i      (wr_tile),
        .wr_idx_i       (wr_idx),
        .wr_re_i        (wr_re),
        .wr_im_i        (wr_im),
        .rd_req_valid_i (rd_req_valid),
        .rd_req_ready_o (rd_req_ready),
        .rd_col_i       (rd_col),
        .rd_tile_i      (rd_tile),
        .rd_idx_i       (rd_idx),
        .rd_valid_o     (rd_valid),
        .rd_re_o        (rd_re),
        .rd_im_o        (rd_im)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h want %h", tag, $time, obs, exp);
        end
    endtask

    // lane k = base + step*k
    function automatic logic [63:0] v4(input int base, input int step);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v[k*16 +: 16] = 16'(base + step * k);
        return v;
    endfunction

    // Expected read returns: driver posts what it expects accepted this cycle,
    // the monitor delays it two cycles and compares.
    logic        exp_rd = 1'b0;
    logic [63:0] exp_re = '0, exp_im = '0;
    logic        p0v = 1'b0, p1v = 1'b0;
    logic [63:0] p0re = '0, p0im = '0, p1re = '0, p1im = '0;
    logic [63:0] last_re = '0, last_im = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            p0v = 1'b0; p1v = 1'b0;
            last_re = '0; last_im = '0;
            chk("rst rd_valid", rd_valid, 1'b0);
        end else begin
            chk("rd_valid", rd_valid, p1v);
            if (p1v) begin
                last_re = p1re;
                last_im = p1im;
            end
            p1v = p0v; p1re = p0re; p1im = p0im;
            p0v = exp_rd; p0re = exp_re; p0im = exp_im;
        end
        chk("rd_re", rd_re, last_re);
        chk("rd_im", rd_im, last_im);
    end

    task automatic cyc(input logic wv, input logic [TW-1:0] wt, input logic wc,
                       input logic [IW-1:0] wi, input logic [63:0] wre, input logic [63:0] wim,
                       input logic rv, input logic [TW-1:0] rt, input logic rc,
                       input logic [IW-1:0] ri, input logic ewr, input logic erd,
                       input logic [63:0] ere, input logic [63:0] eim, input string tag);
        @(posedge clk); #1;
        wr_valid = wv; wr_tile = wt; wr_col = wc; wr_idx = wi; wr_re = wre; wr_im = wim;
        rd_req_valid = rv; rd_tile = rt; rd_col = rc; rd_idx = ri;
        exp_rd = rv & erd; exp_re = ere; exp_im = eim;
        @(negedge clk);
        chk({tag, " wr_ready"}, wr_ready, ewr);
        chk({tag, " rd_ready"}, rd_req_ready, erd);
    endtask

    task automatic wr(input logic [TW-1:0] t, input logic c, input logic [IW-1:0] i,
                      input logic [63:0] re, input logic [63:0] im, input logic ewr, input string tag);
        cyc(1'b1, t, c, i, re, im, 1'b0, '0, 1'b0, '0, ewr, 1'b0, '0, '0, tag);
    endtask

    task automatic rd(input logic [TW-1:0] t, input logic c, input logic [IW-1:0] i,
                      input logic erd, input logic [63:0] ere, input logic [63:0] eim, input string tag);
        cyc(1'b0, '0, 1'b0, '0, '0, '0, 1'b1, t, c, i, 1'b0, erd, ere, eim, tag);
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, "idle");
    endtask

    initial begin
        #2;
        chk("reset rd_valid", rd_valid, 1'b0);
        chk("reset rd_re", rd_re, '0);
        chk("reset rd_im", rd_im, '0);
        chk("reset rd_ready", rd_req_ready, 1'b0);
        #20 rst_n = 1'b1;

        // Fill tile 0 by rows, value 16r+c.
        for (int r = 0; r < 4; r++)
            wr(1'b0, 1'b0, IW'(r), v4(16*r, 1), v4(4096 + 16*r, 1), 1'b1, $sformatf("wrrow%0d", r));
        wr(1'b0, 1'b0, 2'd0, v4(0, 1), v4(0, 1), 1'b0, "wr_full");

        // Drain tile 0 by columns: column c -> lanes {c,16+c,32+c,48+c}.
        for (int c = 0; c < 3; c++)
            rd(1'b0, 1'b1, IW'(c), 1'b1, v4(c, 16), v4(4096 + c, 16), $sformatf("rdcol%0d", c));
        // Last drain read while a write to the still-full tile waits.
        cyc(1'b1, 1'b0, 1'b0, 2'd0, v4(512, 1), v4(4608, 1),
            1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, v4(3, 16), v4(4099, 16), "rdcol3");
        // Tile released: write goes through the next cycle.
        wr(1'b0, 1'b0, 2'd0, v4(512, 1), v4(4608, 1), 1'b1, "wr_release");

        // Tile 1 by columns, value 16c+r; half-filled tile must not be readable.
        wr(1'b1, 1'b1, 2'd0, v4(0, 1), v4(4096, 1), 1'b1, "wrcol0");
        wr(1'b1, 1'b1, 2'd1, v4(16, 1), v4(4112, 1), 1'b1, "wrcol1");
        rd(1'b1, 1'b0, 2'd0, 1'b0, '0, '0, "rd_half");
        wr(1'b1, 1'b1, 2'd2, v4(32, 1), v4(4128, 1), 1'b1, "wrcol2");
        wr(1'b1, 1'b1, 2'd3, v4(48, 1), v4(4144, 1), 1'b1, "wrcol3");

        // Conflict: refill tile 0 rows while draining tile 1 rows -> W,R,W,R.
        cyc(1'b1, 1'b0, 1'b0, 2'd1, v4(528, 1), v4(4624, 1),
            1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, v4(0, 16), v4(4096, 16), "arb1");
        cyc(1'b1, 1'b0, 1'b0, 2'd2, v4(544, 1), v4(4640, 1),
            1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, v4(0, 16), v4(4096, 16), "arb2");
        cyc(1'b1, 1'b0, 1'b0, 2'd2, v4(544, 1), v4(4640, 1),
            1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, v4(1, 16), v4(4097, 16), "arb3");
        cyc(1'b1, 1'b0, 1'b0, 2'd3, v4(560, 1), v4(4656, 1),
            1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, v4(1, 16), v4(4097, 16), "arb4");
        wr(1'b0, 1'b0, 2'd3, v4(560, 1), v4(4656, 1), 1'b1, "wrrow3b");
        rd(1'b1, 1'b0, 2'd2, 1'b1, v4(2, 16), v4(4098, 16), "rdrow2");
        rd(1'b1, 1'b0, 2'd3, 1'b1, v4(3, 16), v4(4099, 16), "rdrow3");

        // Stream tile 0 columns, then reset with reads in flight.
        for (int c = 0; c < 3; c++)
            rd(1'b0, 1'b1, IW'(c), 1'b1, v4(512 + c, 16), v4(4608 + c, 16), $sformatf("rdcolb%0d", c));
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_req_valid = 1'b0; exp_rd = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async rd_valid", rd_valid, 1'b0);
        chk("async rd_re", rd_re, '0);
        chk("async rd_im", rd_im, '0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle();
        idle();
        idle();
        rd(1'b0, 1'b1, 2'd0, 1'b0, '0, '0, "rd_after_rst");
        wr(1'b0, 1'b0, 2'd0, v4(1, 1), v4(2, 1), 1'b1, "wr_after_rst");
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
